xadc_drp_poller: RTL and testbench

- DRP initiator that drives the XADC primitive's Dynamic Reconfiguration Port from fabric logic.
- On each XADC End-of-Sequence pulse, sweeps a fixed list of status-register addresses with DRP reads and publishes 12-bit results.
- Also arbitrates single host-requested DRP writes, for example to the config registers 40h–42h.
- Sits between the XADC instance and the monitoring or alarm logic.

---
 rtl/xadc_drp_poller.sv | 195 +++++++++++++++++++
 tb/tb_xadc_drp_poller.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xadc_drp_poller.sv
// DRP initiator for the XADC: sweeps ADDR_LIST on every EOS and interleaves single host writes.
// Build option: define XADC_AVG_EN to publish a 4-sample average per channel instead of every read.
module xadc_drp_poller #(
   parameter int                  NUM_CH    = 4,
   parameter logic [NUM_CH*7-1:0] ADDR_LIST = {7'h06, 7'h02, 7'h01, 7'h00},
   parameter int                  TIMEOUT   = 63
) (
   input  logic        DCLK,
   input  logic        RESET_N,
   input  logic        EOS,
   input  logic [15:0] DO,
   input  logic        DRDY,
   output logic [6:0]  DADDR,
   output logic        DEN,
   output logic        DWE,
   output logic [15:0] DI,
   input  logic        WR_REQ,
   input  logic [6:0]  WR_ADDR,
   input  logic [15:0] WR_DATA,
   output logic        WR_ACK,
   output logic        RESULT_VALID,
   output logic [3:0]  RESULT_IDX,
   output logic [11:0] RESULT_DATA,
   output logic        TIMEOUT_ERR,
   output logic        POLL_BUSY,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

   localparam logic [3:0]  IDX_LAST = 4'(NUM_CH - 1);
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

   state_t      state, state_n;
   logic [3:0]  idx, idx_n;
   logic        wr_mode, wr_mode_n;
   logic        resume, resume_n;
   logic        pending;
   logic [15:0] tmo_cnt;
   logic        load_issue, load_write, start_sweep;
   logic        timeout_hit, read_end, result_fire;
   logic        unused_do;

   assign unused_do   = ^DO[3:0];
   // DRDY on the last counted cycle still wins over the timeout.
   assign timeout_hit = (state == WAIT) && !DRDY && (tmo_cnt == TMO_LAST);
   assign read_end    = (state == WAIT) && !wr_mode && (DRDY || timeout_hit);

`ifdef XADC_AVG_EN
   logic [13:0] acc  [16];
   logic [1:0]  scnt [16];
   logic        avg_fire;
   logic [13:0] acc_sum;

   assign acc_sum     = acc[idx] + {2'b00, DO[15:4]};
   assign result_fire = avg_fire;
`else
   assign result_fire = 1'b1;
`endif

   always_ff @(posedge DCLK or negedge RESET_N) begin
      if (!RESET_N) state <= IDLE;
      else          state <= state_n;
   end

   always_comb begin
      state_n      = state;
      idx_n        = idx;
      wr_mode_n    = wr_mode;
      resume_n     = resume;
      load_issue   = 1'b0;
      load_write   = 1'b0;
      start_sweep  = 1'b0;
      DEN          = 1'b0;
      DWE          = 1'b0;
      WR_ACK       = 1'b0;
      RESULT_VALID = 1'b0;
      POLL_BUSY    = (state != IDLE);
      dbg_state    = state;
      case (state)
         IDLE: begin
            if (WR_REQ) begin
               wr_mode_n  = 1'b1;
               resume_n   = 1'b0;
               load_issue = 1'b1;
               load_write = 1'b1;
               state_n    = ISSUE;
            end else if (EOS || pending) begin
               idx_n       = 4'd0;
               wr_mode_n   = 1'b0;
               start_sweep = 1'b1;
               load_issue  = 1'b1;
               state_n     = ISSUE;
            end
         end
         ISSUE: begin
            DEN     = 1'b1;
            DWE     = wr_mode;
            state_n = WAIT;
         end
         WAIT: begin
            if (DRDY || timeout_hit) state_n = DONE;
         end
         DONE: begin
            if (wr_mode) begin
               WR_ACK = 1'b1;
               if (resume) begin
                  // A write slipped into a sweep: pick the sweep up at the next entry.
                  resume_n   = 1'b0;
                  wr_mode_n  = 1'b0;
                  idx_n      = idx + 4'd1;
                  load_issue = 1'b1;
                  state_n    = ISSUE;
               end else begin
                  state_n = IDLE;
               end
            end else begin
               RESULT_VALID = result_fire;
               if (idx == IDX_LAST) begin
                  state_n = IDLE;
               end else if (WR_REQ) begin
                  resume_n   = 1'b1;
                  wr_mode_n  = 1'b1;
                  load_issue = 1'b1;
                  load_write = 1'b1;
                  state_n    = ISSUE;
               end else begin
                  idx_n      = idx + 4'd1;
                  load_issue = 1'b1;
                  state_n    = ISSUE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge DCLK or negedge RESET_N) begin
      if (!RESET_N) begin
         idx         <= 4'd0;
         wr_mode     <= 1'b0;
         resume      <= 1'b0;
         pending     <= 1'b0;
         tmo_cnt     <= 16'd0;
         DADDR       <= 7'd0;
         DI          <= 16'd0;
         TIMEOUT_ERR <= 1'b0;
         RESULT_IDX  <= 4'd0;
         RESULT_DATA <= 12'd0;
`ifdef XADC_AVG_EN
         avg_fire    <= 1'b0;
         for (int i = 0; i < 16; i++) begin
            acc[i]  <= 14'd0;
            scnt[i] <= 2'd0;
         end
`endif
      end else begin
         idx     <= idx_n;
         wr_mode <= wr_mode_n;
         resume  <= resume_n;
         // One-deep: EOS pulses beyond the first while busy collapse into one.
         pending <= start_sweep ? 1'b0 : (pending | EOS);
         if (load_issue) begin
            DADDR <= load_write ? WR_ADDR : ADDR_LIST[7*idx_n +: 7];
            DI    <= load_write ? WR_DATA : 16'd0;
         end
         if (state == ISSUE)     tmo_cnt <= 16'd0;
         else if (state == WAIT) tmo_cnt <= tmo_cnt + 16'd1;
         if (timeout_hit) TIMEOUT_ERR <= 1'b1;
`ifdef XADC_AVG_EN
         if (read_end) begin
            avg_fire <= 1'b0;
            if (DRDY) begin
               if (scnt[idx] == 2'd3) begin
                  RESULT_IDX  <= idx;
                  RESULT_DATA <= acc_sum[13:2];
                  acc[idx]    <= 14'd0;
                  scnt[idx]   <= 2'd0;
                  avg_fire    <= 1'b1;
               end else begin
                  acc[idx]  <= acc_sum;
                  scnt[idx] <= scnt[idx] + 2'd1;
               end
            end
         end
`else
         if (read_end) begin
            RESULT_IDX  <= idx;
            RESULT_DATA <= DRDY ? DO[15:4] : 12'h000;
         end
`endif
      end
   end

endmodule

// File: tb/tb_xadc_drp_poller.sv
// Directed bench for xadc_drp_poller: DRP responder, negedge monitor, one task per scenario.
module tb_xadc_drp_poller;

   logic        DCLK = 1'b0;
   logic        RESET_N = 1'b0;
   logic        EOS = 1'b0;
   logic        WR_REQ = 1'b0;
   logic [6:0]  WR_ADDR = 7'd0;
   logic [15:0] WR_DATA = 16'd0;
   logic        DRDY;
   logic [15:0] DO;
   logic [6:0]  DADDR;
   logic        DEN, DWE, WR_ACK, RESULT_VALID, TIMEOUT_ERR, POLL_BUSY;
   logic [15:0] DI;
   logic [3:0]  RESULT_IDX;
   logic [11:0] RESULT_DATA;
   logic [1:0]  dbg_state;

   logic        resp_drdy = 1'b0, man_drdy = 1'b0;
   logic [15:0] resp_do = 16'd0, man_do = 16'd0;
   logic        resp_en = 1'b1;
   logic [6:0]  withhold_addr = 7'h7F;
   logic [11:0] ch0_val = 12'hA5C;

   int nvec = 0;
   int nerr = 0;
   int cyc = 0;
   int last_drdy = 0;
   int ack_cnt = 0;
   logic [15:0] res_q[$];
   logic [23:0] den_q[$];
   int res_cyc_q[$], den_cyc_q[$], lat_q[$], ack_lat_q[$];

   assign DRDY = resp_drdy | man_drdy;
   assign DO   = man_drdy ? man_do : resp_do;

   xadc_drp_poller dut (
      .DCLK(DCLK), .RESET_N(RESET_N), .EOS(EOS), .DO(DO), .DRDY(DRDY),
      .DADDR(DADDR), .DEN(DEN), .DWE(DWE), .DI(DI),
      .WR_REQ(WR_REQ), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .WR_ACK(WR_ACK),
      .RESULT_VALID(RESULT_VALID), .RESULT_IDX(RESULT_IDX), .RESULT_DATA(RESULT_DATA),
      .TIMEOUT_ERR(TIMEOUT_ERR), .POLL_BUSY(POLL_BUSY), .dbg_state(dbg_state)
   );

   // clock / reset block
   always #5 DCLK = ~DCLK;
   always @(posedge DCLK) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [15:0] do_for(input logic [6:0] a);
      case (a)
         7'h00:   return {ch0_val, 4'h0};
         7'h01:   return 16'h5550;
         7'h02:   return 16'h9990;
         7'h06:   return 16'h5550;
         default: return 16'h0000;
      endcase
   endfunction

   // XADC model: DRDY two cycles after the DEN cycle.
   initial begin
      logic [15:0] d;
      forever begin
         @(negedge DCLK);
         if (DEN && resp_en && DADDR != withhold_addr) begin
            d = DWE ? 16'h0000 : do_for(DADDR);
            @(posedge DCLK); #1;
            @(posedge DCLK); #1;
            resp_drdy = 1'b1;
            resp_do   = d;
            @(posedge DCLK); #1;
            resp_drdy = 1'b0;
         end
      end
   end

   // monitor
   initial begin
      forever begin
         @(negedge DCLK);
         if (DRDY) last_drdy = cyc;
         if (DEN) begin
            den_q.push_back({DWE, DADDR, DI});
            den_cyc_q.push_back(cyc);
         end
         if (RESULT_VALID) begin
            res_q.push_back({RESULT_IDX, RESULT_DATA});
            res_cyc_q.push_back(cyc);
            lat_q.push_back(cyc - last_drdy);
         end
         if (WR_ACK) begin
            ack_cnt++;
            ack_lat_q.push_back(cyc - last_drdy);
         end
      end
   end

   // driver tasks
   task automatic step();
      @(posedge DCLK); #1;
   endtask

   task automatic pulse_eos();
      EOS = 1'b1;
      step();
      EOS = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      int quiet = 0;
      while (quiet < 3 && n < budget) begin
         step();
         n++;
         quiet = POLL_BUSY ? 0 : quiet + 1;
      end
      if (quiet < 3) begin
         nvec++; nerr++;
         $display("FAIL wait_idle: still busy after %0d cycles", budget);
      end
   endtask

   task automatic wait_ack(input int budget);
      int n = 0;
      while (!WR_ACK && n < budget) begin
         step();
         n++;
      end
      if (!WR_ACK) begin
         nvec++; nerr++;
         $display("FAIL wait_ack: no WR_ACK within %0d cycles", budget);
      end
      WR_REQ = 1'b0;
   endtask

   task automatic test_reset();
      RESET_N = 1'b0;
      EOS = 1'b0;
      WR_REQ = 1'b0;
      repeat (3) step();
      nvec++;
      if ({DADDR, DEN, DWE, DI, WR_ACK, RESULT_VALID, RESULT_IDX, RESULT_DATA, TIMEOUT_ERR, POLL_BUSY} !== 46'd0) begin
         nerr++;
         $display("FAIL reset_outputs: got DADDR=%h DEN=%b DWE=%b DI=%h ACK=%b RV=%b IDX=%h DATA=%h TERR=%b BUSY=%b, want all 0",
                  DADDR, DEN, DWE, DI, WR_ACK, RESULT_VALID, RESULT_IDX, RESULT_DATA, TIMEOUT_ERR, POLL_BUSY);
      end
      nvec++;
      if (dbg_state !== 2'd0) begin
         nerr++; $display("FAIL reset_state: got %0d want 0", dbg_state);
      end
      RESET_N = 1'b1;
      repeat (2) step();
      nvec++;
      if (POLL_BUSY !== 1'b0) begin
         nerr++; $display("FAIL reset_release_busy: got %b want 0", POLL_BUSY);
      end
   endtask

   task automatic test_sweep();
      logic [15:0] exp_q[$];
      logic [23:0] exp_den[$];
      int r0 = res_q.size();
      int d0 = den_q.size();
      int a0 = ack_cnt;
      exp_q   = '{{4'd0, 12'hA5C}, {4'd1, 12'h555}, {4'd2, 12'h999}, {4'd3, 12'h555}};
      exp_den = '{{1'b0, 7'h00, 16'h0}, {1'b0, 7'h01, 16'h0}, {1'b0, 7'h02, 16'h0}, {1'b0, 7'h06, 16'h0}};
      pulse_eos();
      wait_idle(300);
      nvec++;
      if (res_q.size() - r0 != 4) begin
         nerr++; $display("FAIL sweep_count: got %0d results want 4", res_q.size() - r0);
      end
      for (int i = 0; i < 4; i++) begin
         nvec++;
         if (r0 + i >= res_q.size() || res_q[r0+i] !== exp_q[i]) begin
            nerr++; $display("FAIL sweep_result[%0d]: got %h want %h", i, (r0 + i < res_q.size()) ? res_q[r0+i] : 16'hxxxx, exp_q[i]);
         end
         nvec++;
         if (d0 + i >= den_q.size() || den_q[d0+i] !== exp_den[i]) begin
            nerr++; $display("FAIL sweep_drp[%0d]: got %h want %h", i, (d0 + i < den_q.size()) ? den_q[d0+i] : 24'hxxxxxx, exp_den[i]);
         end
         if (r0 + i < res_q.size() && d0 + i < den_q.size()) begin
            nvec++;
            if (res_cyc_q[r0+i] - den_cyc_q[d0+i] != 3) begin
               nerr++; $display("FAIL sweep_den_to_valid[%0d]: got %0d cycles want 3", i, res_cyc_q[r0+i] - den_cyc_q[d0+i]);
            end
            nvec++;
            if (lat_q[r0+i] != 1) begin
               nerr++; $display("FAIL sweep_drdy_to_valid[%0d]: got %0d want 1", i, lat_q[r0+i]);
            end
         end
      end
      nvec++;
      if (den_q.size() - d0 != 4) begin
         nerr++; $display("FAIL sweep_den_count: got %0d want 4", den_q.size() - d0);
      end
      nvec++;
      if (ack_cnt != a0) begin
         nerr++; $display("FAIL sweep_no_ack: got %0d acks want 0", ack_cnt - a0);
      end
      nvec++;
      if ({TIMEOUT_ERR, RESULT_IDX, RESULT_DATA, DADDR} !== {1'b0, 4'd3, 12'h555, 7'h06}) begin
         nerr++; $display("FAIL sweep_hold: got TERR=%b IDX=%h DATA=%h DADDR=%h want 0/3/555/06", TIMEOUT_ERR, RESULT_IDX, RESULT_DATA, DADDR);
      end
   endtask

   task automatic test_write();
      int r0 = res_q.size();
      int d0 = den_q.size();
      int a0 = ack_cnt;
      int k0 = ack_lat_q.size();
      logic [23:0] exp_w;
      exp_w   = {1'b1, 7'h41, 16'h2000};
      WR_ADDR = 7'h41;
      WR_DATA = 16'h2000;
      WR_REQ  = 1'b1;
      wait_ack(50);
      wait_idle(50);
      nvec++;
      if (den_q.size() - d0 != 1 || den_q[d0] !== exp_w) begin
         nerr++; $display("FAIL write_drp: got %0d DEN, first %h want 1 DEN %h", den_q.size() - d0, (d0 < den_q.size()) ? den_q[d0] : 24'hxxxxxx, exp_w);
      end
      nvec++;
      if (ack_cnt - a0 != 1) begin
         nerr++; $display("FAIL write_ack_count: got %0d want 1", ack_cnt - a0);
      end
      nvec++;
      if (ack_lat_q.size() <= k0 || ack_lat_q[k0] != 1) begin
         nerr++; $display("FAIL write_ack_latency: got %0d want 1", (k0 < ack_lat_q.size()) ? ack_lat_q[k0] : -1);
      end
      nvec++;
      if (res_q.size() != r0) begin
         nerr++; $display("FAIL write_no_result: got %0d results want 0", res_q.size() - r0);
      end
   endtask

   task automatic test_interleave();
      logic [15:0] exp_q[$];
      logic [23:0] exp_den[$];
      int r0 = res_q.size();
      int d0 = den_q.size();
      int a0 = ack_cnt;
      int n = 0;
      exp_q   = '{{4'd0, 12'hA5C}, {4'd1, 12'h555}, {4'd2, 12'h999}, {4'd3, 12'h555}};
      exp_den = '{{1'b0, 7'h00, 16'h0}, {1'b0, 7'h01, 16'h0}, {1'b1, 7'h42, 16'h1234},
                  {1'b0, 7'h02, 16'h0}, {1'b0, 7'h06, 16'h0}};
      pulse_eos();
      while (!(DEN && DADDR == 7'h01) && n < 50) begin
         step();
         n++;
      end
      WR_ADDR = 7'h42;
      WR_DATA = 16'h1234;
      WR_REQ  = 1'b1;
      wait_ack(100);
      wait_idle(300);
      nvec++;
      if (den_q.size() - d0 != 5) begin
         nerr++; $display("FAIL interleave_den_count: got %0d want 5", den_q.size() - d0);
      end
      for (int i = 0; i < 5; i++) begin
         nvec++;
         if (d0 + i >= den_q.size() || den_q[d0+i] !== exp_den[i]) begin
            nerr++; $display("FAIL interleave_drp[%0d]: got %h want %h", i, (d0 + i < den_q.size()) ? den_q[d0+i] : 24'hxxxxxx, exp_den[i]);
         end
      end
      nvec++;
      if (res_q.size() - r0 != 4) begin
         nerr++; $display("FAIL interleave_count: got %0d want 4", res_q.size() - r0);
      end
      for (int i = 0; i < 4; i++) begin
         nvec++;
         if (r0 + i >= res_q.size() || res_q[r0+i] !== exp_q[i]) begin
            nerr++; $display("FAIL interleave_result[%0d]: got %h want %h", i, (r0 + i < res_q.size()) ? res_q[r0+i] : 16'hxxxx, exp_q[i]);
         end
      end
      if (res_q.size() - r0 >= 2 && den_q.size() - d0 >= 3) begin
         nvec++;
         if (den_cyc_q[d0+2] - res_cyc_q[r0+1] != 1) begin
            nerr++; $display("FAIL interleave_write_slot: write DEN %0d cycles after idx1 result, want 1", den_cyc_q[d0+2] - res_cyc_q[r0+1]);
         end
      end
      nvec++;
      if (ack_cnt - a0 != 1) begin
         nerr++; $display("FAIL interleave_ack: got %0d want 1", ack_cnt - a0);
      end
   endtask

   task automatic test_timeout();
      logic [15:0] exp_q[$];
      int r0 = res_q.size();
      int d0 = den_q.size();
      exp_q = '{{4'd0, 12'hA5C}, {4'd1, 12'h555}, {4'd2, 12'h000}, {4'd3, 12'h555}};
      withhold_addr = 7'h02;
      pulse_eos();
      wait_idle(400);
      withhold_addr = 7'h7F;
      nvec++;
      if (res_q.size() - r0 != 4) begin
         nerr++; $display("FAIL timeout_count: got %0d want 4", res_q.size() - r0);
      end
      for (int i = 0; i < 4; i++) begin
         nvec++;
         if (r0 + i >= res_q.size() || res_q[r0+i] !== exp_q[i]) begin
            nerr++; $display("FAIL timeout_result[%0d]: got %h want %h", i, (r0 + i < res_q.size()) ? res_q[r0+i] : 16'hxxxx, exp_q[i]);
         end
      end
      if (res_q.size() - r0 >= 3 && den_q.size() - d0 >= 3) begin
         nvec++;
         if (res_cyc_q[r0+2] - den_cyc_q[d0+2] != 64) begin
            nerr++; $display("FAIL timeout_duration: got %0d cycles DEN-to-valid want 64", res_cyc_q[r0+2] - den_cyc_q[d0+2]);
         end
      end
      nvec++;
      if (TIMEOUT_ERR !== 1'b1) begin
         nerr++; $display("FAIL timeout_err: got %b want 1", TIMEOUT_ERR);
      end
   endtask

   task automatic test_pending();
      logic [15:0] exp_q[$];
      int r0 = res_q.size();
      for (int s = 0; s < 2; s++) begin
         exp_q.push_back({4'd0, 12'hA5C});
         exp_q.push_back({4'd1, 12'h555});
         exp_q.push_back({4'd2, 12'h999});
         exp_q.push_back({4'd3, 12'h555});
      end
      pulse_eos();
      repeat (2) step();
      pulse_eos();
      repeat (5) step();
      pulse_eos();
      wait_idle(400);
      nvec++;
      if (res_q.size() - r0 != 8) begin
         nerr++; $display("FAIL pending_count: got %0d want 8", res_q.size() - r0);
      end
      for (int i = 0; i < 8; i++) begin
         nvec++;
         if (r0 + i >= res_q.size() || res_q[r0+i] !== exp_q[i]) begin
            nerr++; $display("FAIL pending_result[%0d]: got %h want %h", i, (r0 + i < res_q.size()) ? res_q[r0+i] : 16'hxxxx, exp_q[i]);
         end
      end
      nvec++;
      if (TIMEOUT_ERR !== 1'b1) begin
         nerr++; $display("FAIL timeout_sticky: got %b want 1", TIMEOUT_ERR);
      end
   endtask

   task automatic test_reset_mid();
      int r0 = res_q.size();
      int a0 = ack_cnt;
      resp_en = 1'b0;
      pulse_eos();
      step();
      nvec++;
      if (dbg_state !== 2'd2) begin
         nerr++; $display("FAIL reset_mid_setup: state got %0d want 2", dbg_state);
      end
      RESET_N = 1'b0;
      #1;
      nvec++;
      if ({DADDR, DEN, DWE, DI, WR_ACK, RESULT_VALID, RESULT_IDX, RESULT_DATA, TIMEOUT_ERR, POLL_BUSY, dbg_state} !== 48'd0) begin
         nerr++;
         $display("FAIL reset_mid_async: got DADDR=%h DEN=%b DI=%h IDX=%h DATA=%h TERR=%b BUSY=%b ST=%0d, want all 0",
                  DADDR, DEN, DI, RESULT_IDX, RESULT_DATA, TIMEOUT_ERR, POLL_BUSY, dbg_state);
      end
      repeat (2) step();
      RESET_N  = 1'b1;
      man_do   = 16'hFFF0;
      man_drdy = 1'b1;
      repeat (2) step();
      man_drdy = 1'b0;
      repeat (4) step();
      resp_en = 1'b1;
      nvec++;
      if (res_q.size() != r0 || ack_cnt != a0) begin
         nerr++; $display("FAIL reset_mid_stray_drdy: got %0d results %0d acks want 0 0", res_q.size() - r0, ack_cnt - a0);
      end
      nvec++;
      if ({DADDR, DI, RESULT_DATA, TIMEOUT_ERR, POLL_BUSY} !== 37'd0) begin
         nerr++; $display("FAIL reset_mid_after: got DADDR=%h DI=%h DATA=%h TERR=%b BUSY=%b want all 0", DADDR, DI, RESULT_DATA, TIMEOUT_ERR, POLL_BUSY);
      end
   endtask

`ifdef XADC_AVG_EN
   task automatic test_avg();
      logic [15:0] exp_q[$];
      int r0 = res_q.size();
      exp_q = '{{4'd0, 12'h002}, {4'd1, 12'h555}, {4'd2, 12'h999}, {4'd3, 12'h555}};
      for (int k = 1; k <= 4; k++) begin
         ch0_val = 12'(k);
         pulse_eos();
         wait_idle(300);
      end
      ch0_val = 12'hA5C;
      nvec++;
      if (res_q.size() - r0 != 4) begin
         nerr++; $display("FAIL avg_count: got %0d want 4", res_q.size() - r0);
      end
      for (int i = 0; i < 4; i++) begin
         nvec++;
         if (r0 + i >= res_q.size() || res_q[r0+i] !== exp_q[i]) begin
            nerr++; $display("FAIL avg_result[%0d]: got %h want %h", i, (r0 + i < res_q.size()) ? res_q[r0+i] : 16'hxxxx, exp_q[i]);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
`ifdef XADC_AVG_EN
      test_write();
      test_avg();
      test_reset_mid();
`else
      test_sweep();
      test_write();
      test_interleave();
      test_timeout();
      test_pending();
      test_reset_mid();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
